// File: rtl/demux_sched_ctrl_pkg.sv
// demux_sched_pkg: shared state encodings and default sizes for the demux scheduler
package demux_sched_pkg;
  localparam int DATA_W_DEF = 4;
  localparam int CREDITS_DEF = 4;
  typedef enum logic [1:0] {INIT = 2'd0, IDLE = 2'd1, ACTIVE = 2'd2} state_t;
endpackage

// File: rtl/demux_sched_ctrl_if.sv
// demux_sched_ctrl_if: requester handshakes, credit returns and demux-side bus
interface demux_sched_ctrl_if
  import demux_sched_pkg::*;
#(parameter int DATA_W = DATA_W_DEF);
  logic              enable;
  logic              req_valid0, req_valid1;
  logic [DATA_W-1:0] req_data0, req_data1;
  logic              req_dest0, req_dest1;
  logic              credit_ret0, credit_ret1;
  logic              grant0, grant1;
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic              sel;
  modport master (
    output enable, req_valid0, req_data0, req_dest0, req_valid1, req_data1, req_dest1,
           credit_ret0, credit_ret1,
    input  grant0, grant1, valid_in, data_in, sel
  );
  modport slave (
    input  enable, req_valid0, req_data0, req_dest0, req_valid1, req_data1, req_dest1,
           credit_ret0, credit_ret1,
    output grant0, grant1, valid_in, data_in, sel
  );
endinterface

// File: rtl/demux_sched_ctrl_arb.sv
// rr_arb2: two-way round-robin arbiter; pointer remembers the last granted requester
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);
  logic ptr;
  always_comb grant = &req ? (ptr ? 2'b01 : 2'b10) : req;
  always_ff @(posedge clk) begin
    if (reset) ptr <= 1'b1;
    else if (|grant) ptr <= grant[1];
  end
endmodule

// File: rtl/demux_sched_ctrl.sv
// demux_sched_ctrl: credit-based round-robin scheduler feeding a valid/data/sel demux
module demux_sched_ctrl
  import demux_sched_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int CREDITS = CREDITS_DEF,
  parameter int CW      = $clog2(CREDITS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  demux_sched_ctrl_if.slave   bus,
  output logic [CW-1:0]       credits0,
  output logic [CW-1:0]       credits1,
  output logic [1:0]          state,
  output logic                credit_err
);
  state_t st, st_nx;
  logic go;
  logic [1:0] el, gnt, cons, ret, sat;
  logic [1:0][CW-1:0] cred;
  always_ff @(posedge clk) begin
    if (reset) st <= INIT;
    else st <= st_nx;
  end
  always_comb st_nx = (st == INIT) ? IDLE : (bus.enable ? ACTIVE : IDLE);
  always_comb begin
    go = (st == ACTIVE) && bus.enable && !reset;
    state = st;
    credits0 = cred[0];
    credits1 = cred[1];
    bus.grant0 = gnt[0];
    bus.grant1 = gnt[1];
  end
  // eligibility looks only at registered credit counts
  always_comb begin
    el[0] = go && bus.req_valid0 && (cred[bus.req_dest0] != '0);
    el[1] = go && bus.req_valid1 && (cred[bus.req_dest1] != '0);
    ret = {bus.credit_ret1, bus.credit_ret0};
    for (int i = 0; i < 2; i++) begin
      cons[i] = (gnt[0] && bus.req_dest0 == 1'(i)) || (gnt[1] && bus.req_dest1 == 1'(i));
      sat[i] = cred[i] == CW'(CREDITS);
    end
  end
  rr_arb2 u_arb (.clk(clk), .reset(reset), .req(el), .grant(gnt));
  always_ff @(posedge clk) begin
    if (reset) begin
      cred <= '0;
      credit_err <= 1'b0;
    end else if (st == INIT) begin
      cred <= {2{CW'(CREDITS)}};
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cons[i] && !ret[i]) cred[i] <= cred[i] - CW'(1);
        else if (ret[i] && !cons[i] && !sat[i]) cred[i] <= cred[i] + CW'(1);
      end
      if (|(ret & ~cons & sat)) credit_err <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.valid_in <= 1'b0;
      bus.data_in <= '0;
      bus.sel <= 1'b0;
    end else begin
      bus.valid_in <= |gnt;
      if (|gnt) begin
        bus.data_in <= gnt[0] ? bus.req_data0 : bus.req_data1;
        bus.sel <= gnt[0] ? bus.req_dest0 : bus.req_dest1;
      end
    end
  end
endmodule
